// File: rtl/piso_tx_pkg.sv
// Shared types and constants for the framed serial transmitter.
// The state encoding is used by piso_tx; the parity constants select even or odd parity.
package piso_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

endpackage

// File: rtl/piso_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last clock of each serial bit.
// A synchronous clear restarts the count so every state begins a fresh bit period.
module piso_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_end = (cnt == LAST);

endmodule

// File: rtl/piso_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB-first, optional parity, stop bit.
// Every output is decoded from registered state only, so sout has no path from the inputs.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = PARITY_EVEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic PAR_INIT = (PARITY_ODD != PARITY_EVEN);

    state_t         state;
    state_t         state_next;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]  bitcnt;
    logic           par;
    logic           bit_end;
    logic           timer_clear;
    logic           last_bit;

    assign last_bit    = (bitcnt == LAST_BIT);
    // Timer idles at zero and restarts whenever the state is about to change.
    assign timer_clear = (state == IDLE) || (state_next != state);

    piso_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (din_valid) state_next = START;
            START:  if (bit_end) state_next = DATA;
            DATA:   if (bit_end && last_bit) state_next = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY: if (bit_end) state_next = STOP;
            STOP:   if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Parity is folded in bit by bit as data leaves, seeded with the odd/even selector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg  <= '0;
            bitcnt <= '0;
            par    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= (state == STOP) && bit_end;
            if (state == IDLE && din_valid) begin
                shreg  <= din;
                bitcnt <= '0;
                par    <= PAR_INIT;
            end else if (state == DATA && bit_end) begin
                shreg  <= shreg >> 1;
                par    <= par ^ shreg[0];
                bitcnt <= last_bit ? '0 : bitcnt + BW'(1);
            end
        end
    end

    always_comb begin
        din_ready = (state == IDLE);
        busy      = (state != IDLE);
        sout      = 1'b1;
        case (state)
            IDLE:    sout = 1'b1;
            START:   sout = 1'b0;
            DATA:    sout = shreg[0];
            PARITY:  sout = par;
            STOP:    sout = 1'b1;
            default: sout = 1'b1;
        endcase
    end

endmodule
